// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM state type for the register-file dump reader.
package reg_dump_pkg;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/reg_dump_reader_if.sv
// Output word stream of the dump reader: one word per valid/ready handshake.
interface reg_dump_reader_if;
  import reg_dump_pkg::*;

  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutIndex;
  logic              OutLast;

  modport master (output OutValid, OutData, OutIndex, OutLast, input OutReady);
  modport slave  (input OutValid, OutData, OutIndex, OutLast, output OutReady);
endinterface

// File: rtl/reg_dump_reader.sv
// Walks a contiguous register range on the register file's second read port
// and streams each value out, tagged with its index, one word per handshake.
module reg_dump_reader
  import reg_dump_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] FirstReg,
  input  logic [ADDR_W-1:0] LastReg,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [DATA_W-1:0] DataRead,
  output logic              Busy,
  output logic              Done,
  reg_dump_reader_if.master out_if
);

  state_t            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] index_q;
  logic              olast_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      last_q    <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      index_q   <= '0;
      olast_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Abort beats a simultaneous Start; an empty range still pulses Done.
          if (Start && !Abort) begin
            busy_q <= 1'b1;
            if (FirstReg <= LastReg) begin
              cur_q     <= FirstReg;
              last_q    <= LastReg;
              rd_addr_q <= FirstReg;
              state_q   <= READ;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        READ: begin
          if (Abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            data_q  <= DataRead;
            index_q <= cur_q;
            olast_q <= (cur_q == last_q);
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (Abort) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (out_if.OutReady) begin
            valid_q <= 1'b0;
            if (olast_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q     <= cur_q + 1'b1;
              rd_addr_q <= cur_q + 1'b1;
              state_q   <= READ;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ReadRegister    = rd_addr_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign out_if.OutValid = valid_q;
  assign out_if.OutData  = data_q;
  assign out_if.OutIndex = index_q;
  assign out_if.OutLast  = olast_q;

endmodule
